data_ram_lsu: RTL and testbench
===============================

// Module: data_ram_lsu
// PURPOSE
// Load/store initiator driving the 256x16 data RAM write and read ports on behalf of the CPU control unit.
// Accepts one request at a time over a valid/ready handshake: LOAD, STORE, or COPY (block move, src->dst).
// Sequences the RAM strobes and returns a one-cycle response pulse.
// Sits between the CPU datapath (MAR/MBR side) and the data RAM.
// PARAMETERS
// ADDR_W  8   RAM address width; also the COPY length width
// DATA_W  16  RAM word width
// PORTS
// i_clk             in   1       clock; all state changes on posedge
// i_rst_n           in   1       asynchronous reset, active-low
// i_req_valid       in   1       request present
// o_req_ready       out  1       high only in IDLE; transfer = valid & ready at posedge
// i_req_op          in   2       00 LOAD, 01 STORE, 10 COPY, 11 illegal
// i_req_addr        in   ADDR_W  LOAD/STORE address; COPY source base
// i_req_addr2       in   ADDR_W  COPY destination base
// i_req_data        in   DATA_W  STORE data
// i_req_len         in   ADDR_W  COPY word count; 0 = no RAM access
// i_abort           in   1       synchronous abort of the in-progress request
// o_rsp_valid       out  1       one-cycle completion pulse
// o_rsp_err         out  1       valid with o_rsp_valid; 1 = illegal op
// o_rsp_data        out  DATA_W  LOAD data; last copied word for COPY; 0 for STORE/err
// o_ram_write       out  1       RAM write strobe (RAM writes at posedge while high)
// o_ram_addr_write  out  ADDR_W  RAM write address
// o_ram_data_write  out  DATA_W  RAM write data
// o_ram_read        out  1       RAM read enable (RAM read is combinational)
// o_ram_addr_read   out  ADDR_W  RAM read address
// i_ram_data_read   in   DATA_W  RAM read data; 0 when o_ram_read low
// BEHAVIOUR
// - Reset (async): state IDLE; all outputs 0 except o_req_ready = 1; address, count and data registers cleared.
// - FSM states: IDLE, LD, ST, CP_RD, CP_WR, RSP.
// - IDLE: on accept, latch all request fields.
//   - LOAD -> LD; STORE -> ST.
//   - COPY -> CP_RD if len != 0, else RSP.
//   - op 11 -> RSP with err = 1.
// - LD (1 cycle): o_ram_read = 1, o_ram_addr_read = addr; capture i_ram_data_read at posedge; -> RSP.
// - ST (1 cycle): o_ram_write = 1 with latched addr/data; -> RSP.
// - CP_RD (1 cycle): read src into hold register; -> CP_WR.
// - CP_WR (1 cycle): write hold register to dst.
//   - src++, dst++ (mod 2^ADDR_W, 255 wraps to 0); count--.
//   - If count becomes 0 -> RSP, else -> CP_RD.
// - RSP (1 cycle): o_rsp_valid = 1; -> IDLE.
// - Latency from accept edge:
//   - LOAD/STORE: rsp_valid in 2nd cycle.
//   - COPY of N words: rsp_valid in cycle 2N+1 after accept (len 0: 1st cycle).
// - Strobes are Moore outputs (decoded from state only); never both high in the same cycle.
// - Addresses/data outputs are 0 whenever their strobe is low.
// - COPY is a strictly forward, word-by-word sequence. Overlap with dst > src propagates repeated data; this is defined behaviour, not an error.
// - i_abort sampled at posedge in any non-IDLE state:
//   - next state IDLE, no RSP pulse.
//   - A strobe already high in the abort cycle completes (that write lands).
//   - Ignored in IDLE and RSP.
// - i_req_valid held during busy is not consumed (ready = 0); request fields are don't-care when valid = 0.
// - Async reset mid-COPY: strobes drop immediately; partially copied words remain in RAM.
// STRUCTURE
// - Shared package: op encodings (OP_LOAD/OP_STORE/OP_COPY), FSM state encoding, ADDR_W/DATA_W defaults.
// - One sub-module: lsu_copy_cnt, holding the src/dst address incrementers and the down-counter with zero flag.
// - FSM and RAM port decode stay in data_ram_lsu.
// TESTING
// - STORE addr 0x10 data 0xBEEF, then LOAD 0x10 -> o_ram_write one cycle at 0x10; LOAD rsp_data = 0xBEEF, err = 0.
// - COPY src 0x20 dst 0x80 len 3, RAM[0x20..0x22] = 1,2,3 -> RAM[0x80..0x82] = 1,2,3; rsp at cycle 7; rsp_data = 3.
// - COPY src 0xFE dst 0x01 len 4 -> reads 0xFE, 0xFF, 0x00, 0x01; dst 0x01..0x04 (address wrap verified).
// - COPY len 0 -> no strobe ever; rsp_valid in cycle 1. Op 11 -> rsp_valid with err = 1, no strobe.
// - Abort during 2nd CP_WR of len 5 -> exactly 2 words written, no rsp_valid, ready = 1 next cycle.
// - Assert i_rst_n low mid-COPY (asynchronously) -> strobes 0 before next edge; ready = 1; new LOAD after release works.

Source files
------------

// File: rtl/data_ram_lsu_pkg.sv
// Shared definitions for the data RAM load/store unit: default widths,
// request opcode encoding and FSM state encoding.
package data_ram_lsu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_ILL   = 2'b11
    } lsu_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD    = 3'd1,
        S_ST    = 3'd2,
        S_CP_RD = 3'd3,
        S_CP_WR = 3'd4,
        S_RSP   = 3'd5
    } lsu_state_e;

endpackage

// File: rtl/data_ram_lsu_copy_cnt.sv
// lsu_copy_cnt: address/length bookkeeping for the LSU.
// Holds the source and destination addresses and the remaining word count.
// load_i latches a new request; step_i advances both addresses (wrapping
// modulo 2^ADDR_W) and decrements the count.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   load_i              latch src_i/dst_i/len_i
//   step_i              one COPY word done
//   src_i/dst_i/len_i   request base addresses and word count
//   src_o/dst_o         current addresses
//   last_o              count is 1: the current step empties the counter
module lsu_copy_cnt
    import data_ram_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] src_o,
    output logic [ADDR_W-1:0] dst_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (load_i) begin
            src_d = src_i;
            dst_d = dst_i;
            cnt_d = len_i;
        end else if (step_i) begin
            // natural overflow gives the required 255 -> 0 wrap
            src_d = src_q + 1'b1;
            dst_d = dst_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign src_o  = src_q;
    assign dst_o  = dst_q;
    assign last_o = (cnt_q == ADDR_W'(1));

endmodule

// File: rtl/data_ram_lsu.sv
// data_ram_lsu: load/store initiator for the 256x16 data RAM.
// Takes one LOAD / STORE / COPY request at a time over valid/ready,
// drives the RAM read/write strobes from the FSM state, and returns a
// one-cycle response pulse.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_req_* / o_req_ready             request channel (op, addr, addr2, data, len)
//   i_abort                           drop the in-progress request, no response
//   o_rsp_valid/o_rsp_err/o_rsp_data  completion pulse and payload
//   o_ram_write/_addr_write/_data_write  RAM write port
//   o_ram_read/_addr_read, i_ram_data_read  RAM read port (combinational read)
module data_ram_lsu
    import data_ram_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [ADDR_W-1:0] i_req_addr2,
    input  logic [DATA_W-1:0] i_req_data,
    input  logic [ADDR_W-1:0] i_req_len,
    input  logic              i_abort,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_ram_write,
    output logic [ADDR_W-1:0] o_ram_addr_write,
    output logic [DATA_W-1:0] o_ram_data_write,
    output logic              o_ram_read,
    output logic [ADDR_W-1:0] o_ram_addr_read,
    input  logic [DATA_W-1:0] i_ram_data_read
);

    lsu_state_e        state_q;
    logic [DATA_W-1:0] data_q;      // STORE data
    logic [DATA_W-1:0] hold_q;      // COPY word in flight
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic              accept;
    logic              step;
    logic              last;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;

    assign accept = (state_q == S_IDLE) && i_req_valid;
    assign step   = (state_q == S_CP_WR);

    // src doubles as the LOAD/STORE address; dst is only used by COPY
    lsu_copy_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .load_i (accept),
        .step_i (step),
        .src_i  (i_req_addr),
        .dst_i  (i_req_addr2),
        .len_i  (i_req_len),
        .src_o  (src),
        .dst_o  (dst),
        .last_o (last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            hold_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (i_req_valid) begin
                    data_q     <= i_req_data;
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                    case (lsu_op_e'(i_req_op))
                        OP_LOAD:  state_q <= S_LD;
                        OP_STORE: state_q <= S_ST;
                        OP_COPY:  state_q <= (i_req_len == '0) ? S_RSP : S_CP_RD;
                        default: begin
                            state_q   <= S_RSP;
                            rsp_err_q <= 1'b1;
                        end
                    endcase
                end
                S_LD: begin
                    rsp_data_q <= i_ram_data_read;
                    state_q    <= i_abort ? S_IDLE : S_RSP;
                end
                S_ST:    state_q <= i_abort ? S_IDLE : S_RSP;
                S_CP_RD: begin
                    hold_q  <= i_ram_data_read;
                    state_q <= i_abort ? S_IDLE : S_CP_WR;
                end
                S_CP_WR: begin
                    // the write strobe is already up, so this word lands even on abort
                    rsp_data_q <= hold_q;
                    if (i_abort)   state_q <= S_IDLE;
                    else if (last) state_q <= S_RSP;
                    else           state_q <= S_CP_RD;
                end
                S_RSP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode; every address/data output is forced to 0 while its strobe is low
    always_comb begin
        o_req_ready      = (state_q == S_IDLE);
        o_rsp_valid      = (state_q == S_RSP);
        o_rsp_err        = o_rsp_valid & rsp_err_q;
        o_rsp_data       = o_rsp_valid ? rsp_data_q : '0;
        o_ram_read       = (state_q == S_LD) || (state_q == S_CP_RD);
        o_ram_addr_read  = o_ram_read ? src : '0;
        o_ram_write      = 1'b0;
        o_ram_addr_write = '0;
        o_ram_data_write = '0;
        if (state_q == S_ST) begin
            o_ram_write      = 1'b1;
            o_ram_addr_write = src;
            o_ram_data_write = data_q;
        end else if (state_q == S_CP_WR) begin
            o_ram_write      = 1'b1;
            o_ram_addr_write = dst;
            o_ram_data_write = hold_q;
        end
    end

endmodule

// File: tb/tb_data_ram_lsu.sv
// Directed bench for data_ram_lsu with a behavioural 256x16 RAM.
module tb_data_ram_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [7:0]  req_addr = '0, req_addr2 = '0, req_len = '0;
    logic [15:0] req_data = '0;
    logic        abort = 1'b0;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic        ram_wr, ram_rd;
    logic [7:0]  ram_wa, ram_ra;
    logic [15:0] ram_wd, ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_ram_lsu dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_addr2(req_addr2),
        .i_req_data(req_data), .i_req_len(req_len), .i_abort(abort),
        .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
        .o_ram_write(ram_wr), .o_ram_addr_write(ram_wa), .o_ram_data_write(ram_wd),
        .o_ram_read(ram_rd), .o_ram_addr_read(ram_ra), .i_ram_data_read(ram_rdata)
    );

    bit [15:0] mem [256];
    always @(posedge clk) if (ram_wr) mem[ram_wa] <= ram_wd;
    assign ram_rdata = ram_rd ? mem[ram_ra] : 16'h0;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a, a2, len;
        logic [15:0] d;
        int          lat;
        logic        err;
        logic [15:0] data;
        int          nwr, nrd;
        logic [7:0]  ra0, ral, wal;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // strobe exclusivity and zeroed outputs when idle
    task automatic inv_check();
        total++;
        if ((ram_rd && ram_wr) || (!ram_rd && ram_ra != 0) ||
            (!ram_wr && (ram_wa != 0 || ram_wd != 0)) ||
            (!rsp_valid && (rsp_err || rsp_data != 0))) begin
            bad++;
            $display("FAIL invariant: rd=%b ra=%h wr=%b wa=%h wd=%h rv=%b re=%b rdat=%h",
                     ram_rd, ram_ra, ram_wr, ram_wa, ram_wd, rsp_valid, rsp_err, rsp_data);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] a, a2, len, input logic [15:0] d);
        req_valid = 1'b1; req_op = op; req_addr = a; req_addr2 = a2; req_len = len; req_data = d;
    endtask

    task automatic run_req(input vec_t v, output int lat, output logic err, output logic [15:0] rdata,
                           output int nwr, output int nrd,
                           output logic [7:0] ra0, output logic [7:0] ral, output logic [7:0] wal);
        lat = 0; err = 0; rdata = 0; nwr = 0; nrd = 0; ra0 = 0; ral = 0; wal = 0;
        @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 1);
        drive(v.op, v.a, v.a2, v.len, v.d);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_op = 2'b11; req_addr = 8'h5A; req_addr2 = 8'hA5; req_data = 16'hDEAD; req_len = 8'hFF;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            inv_check();
            if (ram_rd) begin
                if (nrd == 0) ra0 = ram_ra;
                ral = ram_ra;
                nrd++;
            end
            if (ram_wr) begin
                wal = ram_wa;
                nwr++;
            end
            if (rsp_valid) begin
                lat = c; err = rsp_err; rdata = rsp_data;
            end
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, a2, len, input logic [15:0] d,
                                input int lat, input logic err, input logic [15:0] data,
                                input int nwr, nrd, input logic [7:0] ra0, ral, wal);
        vec_t v;
        v.op = op; v.a = a; v.a2 = a2; v.len = len; v.d = d; v.lat = lat; v.err = err;
        v.data = data; v.nwr = nwr; v.nrd = nrd; v.ra0 = ra0; v.ral = ral; v.wal = wal;
        return v;
    endfunction

    function automatic vec_t st(input logic [7:0] a, input logic [15:0] d);
        return mk(2'b01, a, 8'h00, 8'h00, d, 2, 1'b0, 16'h0, 1, 0, 8'h0, 8'h0, a);
    endfunction

    function automatic vec_t ld(input logic [7:0] a, input logic [15:0] v);
        return mk(2'b00, a, 8'h00, 8'h00, 16'h0, 2, 1'b0, v, 0, 1, a, a, 8'h0);
    endfunction

    task automatic check_vec(input vec_t v, input int idx);
        int lat, nwr, nrd;
        logic err;
        logic [15:0] rdata;
        logic [7:0] ra0, ral, wal;
        string p;
        run_req(v, lat, err, rdata, nwr, nrd, ra0, ral, wal);
        p = $sformatf("v%0d_", idx);
        chk({p, "lat"}, lat, v.lat);
        chk({p, "err"}, {31'b0, err}, {31'b0, v.err});
        chk({p, "data"}, {16'b0, rdata}, {16'b0, v.data});
        chk({p, "nwr"}, nwr, v.nwr);
        chk({p, "nrd"}, nrd, v.nrd);
        chk({p, "ra0"}, {24'b0, ra0}, {24'b0, v.ra0});
        chk({p, "ral"}, {24'b0, ral}, {24'b0, v.ral});
        chk({p, "wal"}, {24'b0, wal}, {24'b0, v.wal});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        logic saw_rsp;

        // reset state
        #3;
        chk("rst_ready", {31'b0, req_ready}, 1);
        chk("rst_strobes", {30'b0, ram_wr, ram_rd}, 0);
        chk("rst_rsp", {15'b0, rsp_valid, rsp_data}, 0);
        chk("rst_addrs", {ram_wa, ram_ra, ram_wd}, 0);
        @(negedge clk) rst_n = 1'b1;

        vq.push_back(st(8'h10, 16'hBEEF));
        vq.push_back(ld(8'h10, 16'hBEEF));
        vq.push_back(st(8'h20, 16'd1));
        vq.push_back(st(8'h21, 16'd2));
        vq.push_back(st(8'h22, 16'd3));
        vq.push_back(mk(2'b10, 8'h20, 8'h80, 8'd3, 16'h0, 7, 1'b0, 16'd3, 3, 3, 8'h20, 8'h22, 8'h82));
        vq.push_back(ld(8'h80, 16'd1));
        vq.push_back(ld(8'h81, 16'd2));
        vq.push_back(ld(8'h82, 16'd3));
        vq.push_back(st(8'hFE, 16'h00A1));
        vq.push_back(st(8'hFF, 16'h00A2));
        vq.push_back(st(8'h00, 16'h00A3));
        vq.push_back(st(8'h01, 16'h00A4));
        // src wraps FE,FF,00,01; dst 01 is written first, so word 4 re-reads A1
        vq.push_back(mk(2'b10, 8'hFE, 8'h01, 8'd4, 16'h0, 9, 1'b0, 16'h00A1, 4, 4, 8'hFE, 8'h01, 8'h04));
        vq.push_back(ld(8'h01, 16'h00A1));
        vq.push_back(ld(8'h02, 16'h00A2));
        vq.push_back(ld(8'h03, 16'h00A3));
        vq.push_back(ld(8'h04, 16'h00A1));
        vq.push_back(mk(2'b10, 8'h10, 8'h90, 8'd0, 16'h0, 1, 1'b0, 16'h0, 0, 0, 8'h0, 8'h0, 8'h0));
        vq.push_back(ld(8'h90, 16'h0));
        vq.push_back(mk(2'b11, 8'h10, 8'h90, 8'd2, 16'h1234, 1, 1'b1, 16'h0, 0, 0, 8'h0, 8'h0, 8'h0));
        for (int i = 0; i < 5; i++) vq.push_back(st(8'h40 + 8'(i), 16'h11 + 16'(i)));

        foreach (vq[i]) check_vec(vq[i], i);

        // abort in the second CP_WR of a 5-word COPY
        @(negedge clk);
        drive(2'b10, 8'h40, 8'hC0, 8'd5, 16'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        nwr = 0;
        saw_rsp = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_wr) nwr++;
            if (rsp_valid) saw_rsp = 1'b1;
            if (c == 4) begin
                chk("abort_cyc4_write", {31'b0, ram_wr}, 1);
                abort = 1'b1;
            end
            if (c == 5) begin
                abort = 1'b0;
                chk("abort_ready_next", {31'b0, req_ready}, 1);
            end
        end
        chk("abort_nwr", nwr, 2);
        chk("abort_no_rsp", {31'b0, saw_rsp}, 0);
        check_vec(ld(8'hC1, 16'h12), 100);
        check_vec(ld(8'hC2, 16'h0), 101);

        // async reset in the middle of a COPY
        @(negedge clk);
        drive(2'b10, 8'h20, 8'hA0, 8'd3, 16'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_pre_write", {31'b0, ram_wr}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strobes", {30'b0, ram_wr, ram_rd}, 0);
        chk("arst_ready", {31'b0, req_ready}, 1);
        @(negedge clk) rst_n = 1'b1;
        check_vec(ld(8'h10, 16'hBEEF), 102);
        check_vec(ld(8'hA0, 16'h0), 103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
